// File: rtl/parking_slot_allocator.sv
// Parking slot allocator: synchronizes the space sensors, reserves the
// lowest free space on an entry request, sequences the entry and exit gates
// and reports free-space count and lot-full for the entrance display.
module parking_slot_allocator #(
    parameter int N_SPACES     = 8,
    parameter int GATE_CYCLES  = 16,
    parameter int PARK_TIMEOUT = 1024,
    parameter int TMR_W        = 11
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_SPACES-1:0]           sensors,
    input  logic                          entry_req,
    input  logic                          exit_req,
    output logic                          entry_grant,
    output logic                          entry_deny,
    output logic [$clog2(N_SPACES)-1:0]   assigned_slot,
    output logic                          entry_gate_open,
    output logic                          exit_gate_open,
    output logic                          park_timeout,
    output logic [N_SPACES-1:0]           reserved,
    output logic [$clog2(N_SPACES+1)-1:0] free_count,
    output logic                          lot_full
);

    localparam int SLOT_W = $clog2(N_SPACES);
    localparam int CNT_W  = $clog2(N_SPACES + 1);
    localparam logic [TMR_W-1:0] GATE_LAST = TMR_W'(GATE_CYCLES - 1);
    localparam logic [TMR_W-1:0] PARK_LAST = TMR_W'(PARK_TIMEOUT - 1);

    typedef enum logic [1:0] {E_IDLE, E_GATE, E_WAIT} e_state_t;
    typedef enum logic       {X_IDLE, X_OPEN}         x_state_t;

    logic [N_SPACES-1:0] sync_reg, occ_reg, free;
    logic                entry_req_d_reg, exit_req_d_reg;
    logic                entry_rise, exit_rise;
    logic [SLOT_W-1:0]   low_free;

    e_state_t            e_state_reg, e_state_next;
    logic [TMR_W-1:0]    gate_tmr_reg, gate_tmr_next;
    logic [TMR_W-1:0]    park_tmr_reg, park_tmr_next;
    logic [N_SPACES-1:0] reserved_reg, reserved_next;
    logic [SLOT_W-1:0]   slot_reg, slot_next;
    logic                grant_reg, grant_next, deny_reg, deny_next;
    logic                egate_reg, egate_next, pto_reg, pto_next;
    logic                res_hit, occ_clear, tmo, res_after;

    x_state_t            x_state_reg, x_state_next;
    logic [TMR_W-1:0]    xtmr_reg, xtmr_next;
    logic                xgate_reg, xgate_next;

    // Two-flop synchronizer for the sensors plus request edge-detect history.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_reg        <= '0;
            occ_reg         <= '0;
            entry_req_d_reg <= 1'b0;
            exit_req_d_reg  <= 1'b0;
        end else begin
            sync_reg        <= sensors;
            occ_reg         <= sync_reg;
            entry_req_d_reg <= entry_req;
            exit_req_d_reg  <= exit_req;
        end
    end

    assign entry_rise = entry_req & ~entry_req_d_reg;
    assign exit_rise  = exit_req & ~exit_req_d_reg;

    for (genvar gi = 0; gi < N_SPACES; gi++) begin : g_free
        assign free[gi] = ~occ_reg[gi] & ~reserved_reg[gi];
    end

    // Count of free spaces and index of the lowest free space.
    always_comb begin
        free_count = '0;
        low_free   = '0;
        for (int i = 0; i < N_SPACES; i++) begin
            free_count = free_count + CNT_W'(free[i]);
        end
        for (int i = N_SPACES - 1; i >= 0; i--) begin
            if (free[i]) low_free = SLOT_W'(i);
        end
    end

    assign lot_full = (free_count == '0);

    // Entry sequencing: grant/deny, gate timing and reservation release.
    always_comb begin
        e_state_next  = e_state_reg;
        gate_tmr_next = gate_tmr_reg;
        park_tmr_next = park_tmr_reg;
        reserved_next = reserved_reg;
        slot_next     = slot_reg;
        egate_next    = egate_reg;
        grant_next    = 1'b0;
        deny_next     = 1'b0;
        pto_next      = 1'b0;

        // Occupancy confirmation takes precedence over the timeout.
        res_hit   = reserved_reg[slot_reg];
        occ_clear = res_hit & occ_reg[slot_reg];
        tmo       = res_hit & ~occ_clear & (park_tmr_reg == PARK_LAST);
        res_after = res_hit & ~occ_clear & ~tmo;

        if (e_state_reg != E_IDLE) begin
            if (res_hit) park_tmr_next = park_tmr_reg + TMR_W'(1);
            if (occ_clear || tmo) reserved_next = '0;
            pto_next = tmo;
        end

        case (e_state_reg)
            E_IDLE: begin
                if (entry_rise) begin
                    if (lot_full) begin
                        deny_next = 1'b1;
                    end else begin
                        grant_next              = 1'b1;
                        slot_next               = low_free;
                        reserved_next           = '0;
                        reserved_next[low_free] = 1'b1;
                        egate_next              = 1'b1;
                        gate_tmr_next           = '0;
                        park_tmr_next           = '0;
                        e_state_next            = E_GATE;
                    end
                end
            end
            E_GATE: begin
                gate_tmr_next = gate_tmr_reg + TMR_W'(1);
                if (gate_tmr_reg == GATE_LAST) begin
                    egate_next   = 1'b0;
                    e_state_next = res_after ? E_WAIT : E_IDLE;
                end
            end
            E_WAIT: begin
                egate_next = 1'b0;
                if (!res_after) e_state_next = E_IDLE;
            end
            default: e_state_next = E_IDLE;
        endcase
    end

    // Entry state and registered entry outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            e_state_reg  <= E_IDLE;
            gate_tmr_reg <= '0;
            park_tmr_reg <= '0;
            reserved_reg <= '0;
            slot_reg     <= '0;
            grant_reg    <= 1'b0;
            deny_reg     <= 1'b0;
            egate_reg    <= 1'b0;
            pto_reg      <= 1'b0;
        end else begin
            e_state_reg  <= e_state_next;
            gate_tmr_reg <= gate_tmr_next;
            park_tmr_reg <= park_tmr_next;
            reserved_reg <= reserved_next;
            slot_reg     <= slot_next;
            grant_reg    <= grant_next;
            deny_reg     <= deny_next;
            egate_reg    <= egate_next;
            pto_reg      <= pto_next;
        end
    end

    // Exit gate sequencing; independent of reservations.
    always_comb begin
        x_state_next = x_state_reg;
        xtmr_next    = xtmr_reg;
        xgate_next   = xgate_reg;
        case (x_state_reg)
            X_IDLE: begin
                if (exit_rise) begin
                    x_state_next = X_OPEN;
                    xtmr_next    = '0;
                    xgate_next   = 1'b1;
                end
            end
            X_OPEN: begin
                xtmr_next = xtmr_reg + TMR_W'(1);
                if (xtmr_reg == GATE_LAST) begin
                    xgate_next   = 1'b0;
                    x_state_next = X_IDLE;
                end
            end
            default: x_state_next = X_IDLE;
        endcase
    end

    // Exit state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_state_reg <= X_IDLE;
            xtmr_reg    <= '0;
            xgate_reg   <= 1'b0;
        end else begin
            x_state_reg <= x_state_next;
            xtmr_reg    <= xtmr_next;
            xgate_reg   <= xgate_next;
        end
    end

    assign entry_grant     = grant_reg;
    assign entry_deny      = deny_reg;
    assign assigned_slot   = slot_reg;
    assign entry_gate_open = egate_reg;
    assign exit_gate_open  = xgate_reg;
    assign park_timeout    = pto_reg;
    assign reserved        = reserved_reg;

endmodule

// File: tb/tb_parking_slot_allocator.sv
// Bench for parking_slot_allocator: table of entry decisions, hand-written
// multi-cycle sequences, then random traffic against a timeline-based model.
module tb_parking_slot_allocator;

    localparam int G = 4;
    localparam int P = 20;

    logic       clk = 1'b0;
    logic       rst, entry_req, exit_req;
    logic [7:0] sensors;
    logic       entry_grant, entry_deny, entry_gate_open, exit_gate_open, park_timeout, lot_full;
    logic [2:0] assigned_slot;
    logic [7:0] reserved;
    logic [3:0] free_count;

    int checks = 0;
    int errors = 0;

    parking_slot_allocator #(
        .N_SPACES(8), .GATE_CYCLES(G), .PARK_TIMEOUT(P), .TMR_W(11)
    ) dut (
        .clk(clk), .rst(rst), .sensors(sensors),
        .entry_req(entry_req), .exit_req(exit_req),
        .entry_grant(entry_grant), .entry_deny(entry_deny),
        .assigned_slot(assigned_slot),
        .entry_gate_open(entry_gate_open), .exit_gate_open(exit_gate_open),
        .park_timeout(park_timeout), .reserved(reserved),
        .free_count(free_count), .lot_full(lot_full)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        entry_req = 1'b0;
        exit_req  = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    // ---------------- table of single-request entry decisions ----------------
    typedef struct {
        logic [7:0] sens;
        int         fc_pre;
        bit         full_pre;
        bit         grant;
        bit         deny;
        int         slot;
        logic [7:0] res;
        int         fc_post;
    } vec_t;

    vec_t vecs[7];

    // ---------------- reference model (absolute-time view) ----------------
    int         m_n, m_g, m_xg, m_slot, m_res_slot;
    bit         m_res_valid, m_eprev, m_xprev, m_grant, m_deny, m_pto, m_egate, m_xgate;
    logic [7:0] m_occ, m_s1;

    function automatic logic [7:0] m_resmask();
        logic [7:0] one = 8'h01;
        return m_res_valid ? (one << m_res_slot) : 8'h00;
    endfunction

    function automatic int popc(input logic [7:0] v);
        int c = 0;
        for (int i = 0; i < 8; i++) c += int'(v[i]);
        return c;
    endfunction

    // Advance the model by one clock edge with the inputs present at that edge.
    task automatic model_edge(input logic [7:0] s, input bit er, input bit xr, input bit r);
        logic [7:0] free_pre;
        bit         e_idle, x_idle;
        m_grant = 0; m_deny = 0; m_pto = 0;
        if (r) begin
            m_res_valid = 0; m_res_slot = 0; m_slot = 0;
            m_g = -1000; m_xg = -1000;
            m_occ = 8'h00; m_s1 = 8'h00;
            m_eprev = 0; m_xprev = 0; m_egate = 0; m_xgate = 0;
            m_n++;
            return;
        end
        free_pre = ~m_occ & ~m_resmask();
        e_idle   = !m_res_valid && (m_n > m_g + G);
        x_idle   = (m_n > m_xg + G);
        if (m_res_valid) begin
            if (m_occ[m_res_slot]) m_res_valid = 0;
            else if (m_n - m_g == P) begin
                m_res_valid = 0;
                m_pto       = 1;
            end
        end
        if (e_idle && er && !m_eprev) begin
            if (popc(free_pre) == 0) m_deny = 1;
            else begin
                for (int i = 7; i >= 0; i--) if (free_pre[i]) m_slot = i;
                m_res_slot  = m_slot;
                m_res_valid = 1;
                m_g         = m_n;
                m_grant     = 1;
            end
        end
        if (x_idle && xr && !m_xprev) m_xg = m_n;
        m_egate = (m_n >= m_g) && (m_n < m_g + G);
        m_xgate = (m_n >= m_xg) && (m_n < m_xg + G);
        m_occ   = m_s1;
        m_s1    = s;
        m_eprev = er;
        m_xprev = xr;
        m_n++;
    endtask

    task automatic tick();
        model_edge(sensors, entry_req, exit_req, rst);
        step();
    endtask

    task automatic compare_model(input int cyc);
        logic [20:0] act, exp;
        logic [7:0]  mres;
        int          mfc;
        mres = m_resmask();
        mfc  = popc(~m_occ & ~mres);
        act  = {entry_grant, entry_deny, assigned_slot, reserved, entry_gate_open,
                exit_gate_open, park_timeout, free_count, lot_full};
        exp  = {m_grant, m_deny, 3'(m_slot), mres, m_egate, m_xgate, m_pto,
                4'(mfc), (mfc == 0)};
        chk($sformatf("rand_cycle_%0d", cyc), 32'(act), 32'(exp));
        if (m_grant || m_deny || m_pto)
            $display("rand cyc %0d grant=%0b deny=%0b timeout=%0b slot=%0d reserved=%h",
                     cyc, m_grant, m_deny, m_pto, m_slot, mres);
    endtask

    initial begin
        bit bad;
        bit pto_seen;
        int k;
        sensors   = 8'h00;
        entry_req = 1'b0;
        exit_req  = 1'b0;
        rst       = 1'b1;
        step();
        step();

        // Reset state of every registered output.
        chk("rst_grant", 32'(entry_grant), 0);
        chk("rst_deny", 32'(entry_deny), 0);
        chk("rst_slot", 32'(assigned_slot), 0);
        chk("rst_reserved", 32'(reserved), 0);
        chk("rst_egate", 32'(entry_gate_open), 0);
        chk("rst_xgate", 32'(exit_gate_open), 0);
        chk("rst_timeout", 32'(park_timeout), 0);
        rst = 1'b0;

        vecs[0] = '{8'b0000_0101, 6, 0, 1, 0, 1, 8'h02, 5};
        vecs[1] = '{8'hFF,        0, 1, 0, 1, 0, 8'h00, 0};
        vecs[2] = '{8'h00,        8, 0, 1, 0, 0, 8'h01, 7};
        vecs[3] = '{8'h7F,        1, 0, 1, 0, 7, 8'h80, 0};
        vecs[4] = '{8'b1110_1111, 1, 0, 1, 0, 4, 8'h10, 0};
        vecs[5] = '{8'hFE,        1, 0, 1, 0, 0, 8'h01, 0};
        vecs[6] = '{8'b0101_0011, 4, 0, 1, 0, 2, 8'h04, 3};

        foreach (vecs[i]) begin
            sensors = vecs[i].sens;
            do_reset();
            step(); step(); step();
            chk($sformatf("v%0d_fc_pre", i), 32'(free_count), vecs[i].fc_pre);
            chk($sformatf("v%0d_full_pre", i), 32'(lot_full), 32'(vecs[i].full_pre));
            entry_req = 1'b1;
            step();
            chk($sformatf("v%0d_grant", i), 32'(entry_grant), 32'(vecs[i].grant));
            chk($sformatf("v%0d_deny", i), 32'(entry_deny), 32'(vecs[i].deny));
            chk($sformatf("v%0d_slot", i), 32'(assigned_slot), vecs[i].slot);
            chk($sformatf("v%0d_reserved", i), 32'(reserved), 32'(vecs[i].res));
            chk($sformatf("v%0d_egate", i), 32'(entry_gate_open), 32'(vecs[i].grant));
            chk($sformatf("v%0d_fc_post", i), 32'(free_count), vecs[i].fc_post);
            step();
            chk($sformatf("v%0d_pulse_end", i), 32'({entry_grant, entry_deny}), 0);
            entry_req = 1'b0;
            $display("vec %0d sensors=%h grant=%0b deny=%0b slot=%0d reserved=%h free=%0d",
                     i, vecs[i].sens, entry_grant, entry_deny, assigned_slot, reserved, free_count);
        end

        // Park confirmation: gate open for G cycles, sensor clears the reservation.
        sensors = 8'b0000_0101;
        do_reset();
        step(); step(); step();
        entry_req = 1'b1;
        step();
        entry_req = 1'b0;
        chk("park_grant", 32'(entry_grant), 1);
        chk("park_slot", 32'(assigned_slot), 1);
        chk("park_fc", 32'(free_count), 5);
        for (int j = 1; j < G; j++) begin
            step();
            chk($sformatf("park_gate_%0d", j), 32'(entry_gate_open), 1);
        end
        step();
        chk("park_gate_closed", 32'(entry_gate_open), 0);
        step(); step();
        sensors = 8'b0000_0111;
        k = 0;
        pto_seen = 0;
        while (reserved != 8'h00 && k < 5) begin
            step();
            k++;
            if (park_timeout) pto_seen = 1;
        end
        chk("park_clear_latency_ok", 32'(k >= 2 && k <= 3), 1);
        for (int j = 0; j < 25; j++) begin
            step();
            if (park_timeout) pto_seen = 1;
        end
        chk("park_no_timeout", 32'(pto_seen), 0);
        chk("park_fc_after", 32'(free_count), 5);
        entry_req = 1'b1;
        step();
        entry_req = 1'b0;
        chk("park_next_grant", 32'(entry_grant), 1);
        chk("park_next_slot", 32'(assigned_slot), 3);
        $display("seq park: cleared after %0d cycles, next slot=%0d", k, assigned_slot);

        // Timeout: sensor never asserted, pulse exactly P cycles after grant.
        sensors = 8'h00;
        do_reset();
        step(); step(); step();
        entry_req = 1'b1;
        step();
        entry_req = 1'b0;
        chk("tmo_grant", 32'(entry_grant), 1);
        bad = 0;
        for (int j = 1; j < P; j++) begin
            step();
            if (park_timeout || reserved != 8'h01) bad = 1;
        end
        chk("tmo_early", 32'(bad), 0);
        step();
        chk("tmo_pulse", 32'(park_timeout), 1);
        chk("tmo_reserved", 32'(reserved), 0);
        chk("tmo_fc", 32'(free_count), 8);
        step();
        chk("tmo_pulse_end", 32'(park_timeout), 0);
        $display("seq timeout: pulse at grant+%0d", P);

        // Simultaneous entry and exit; a second entry rise during the gate is dropped.
        sensors = 8'h00;
        do_reset();
        step(); step(); step();
        entry_req = 1'b1;
        exit_req  = 1'b1;
        step();
        entry_req = 1'b0;
        exit_req  = 1'b0;
        chk("sim_grant", 32'(entry_grant), 1);
        chk("sim_slot", 32'(assigned_slot), 0);
        chk("sim_gates", 32'({entry_gate_open, exit_gate_open}), 3);
        step();
        entry_req = 1'b1;
        step();
        chk("sim_regrant_ignored", 32'(entry_grant), 0);
        chk("sim_reserved_one", 32'(reserved), 1);
        step();
        chk("sim_gates_last", 32'({entry_gate_open, exit_gate_open}), 3);
        step();
        chk("sim_gates_closed", 32'({entry_gate_open, exit_gate_open}), 0);
        entry_req = 1'b0;
        $display("seq simultaneous: both gates cycled, slot=%0d", assigned_slot);

        // Reset two cycles into the entry gate.
        sensors = 8'h00;
        do_reset();
        step(); step(); step();
        entry_req = 1'b1;
        step();
        entry_req = 1'b0;
        step(); step();
        rst = 1'b1;
        #1;
        chk("rmid_gate", 32'(entry_gate_open), 0);
        chk("rmid_reserved", 32'(reserved), 0);
        step();
        chk("rmid_pulses", 32'({entry_grant, entry_deny, park_timeout}), 0);
        step();
        rst = 1'b0;
        step(); step(); step();
        entry_req = 1'b1;
        step();
        entry_req = 1'b0;
        chk("rmid_regrant", 32'(entry_grant), 1);
        chk("rmid_slot", 32'(assigned_slot), 0);
        chk("rmid_res", 32'(reserved), 1);
        $display("seq reset-mid: regranted slot=%0d", assigned_slot);

        // Random traffic against the model.
        m_n = 0;
        sensors   = 8'h00;
        entry_req = 1'b0;
        exit_req  = 1'b0;
        rst       = 1'b1;
        tick();
        compare_model(-1);
        rst = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            if ($urandom_range(0, 5) == 0) entry_req = ~entry_req;
            if ($urandom_range(0, 7) == 0) exit_req = ~exit_req;
            case ($urandom_range(0, 39))
                0:       sensors = 8'($urandom);
                1:       sensors = 8'hFF;
                2:       sensors = 8'h00;
                3, 4, 5: if (m_res_valid) sensors[m_res_slot] = 1'b1;
                6, 7:    sensors[$urandom_range(0, 7)] = 1'b0;
                default: ;
            endcase
            rst = ($urandom_range(0, 299) == 0);
            tick();
            compare_model(c);
        end
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
